int2fp_convert: RTL and testbench
=================================

// Module: int2fp_convert
// PURPOSE
//  Pipelined 32-bit integer -> IEEE-754 single-precision converter; the inverse of fp_convert (float->int).
//  Synthesizable, no DPI. Fixed 6-cycle latency, so int2fp and fp2int ops schedule identically in the ALU pipe.
//  Accepts one operand per cycle; a global stall freezes the whole pipe for backpressure from the writeback stage.
// PARAMETERS
//  SIGNED   1   1: dataa is two's-complement int32; 0: dataa is uint32
// PORTS
//  clock      in   1   rising-edge clock
//  reset      in   1   synchronous, active-high
//  en         in   1   pipeline advance; 0 = hold every stage (stall)
//  in_valid   in   1   dataa carries an operand this cycle (sampled only when en=1)
//  dataa      in   32  integer operand
//  out_valid  out  1   result is a finished conversion
//  result     out  32  fp32 bit pattern {sign, exp[7:0], frac[22:0]}
// BEHAVIOUR
//  Reset: all stage valid bits <= 0; all data regs <= 0; out_valid=0, result=32'h0 the cycle after reset.
//  Latency: operand accepted on edge N (en=1, in_valid=1) appears on result/out_valid after edge N+5 (6 registers),
//    provided en=1 on all 6 edges; each en=0 cycle adds exactly one cycle. Throughput 1/cycle.
//  Stall: en=0 -> no register changes, including valid bits; outputs hold. in_valid/dataa ignored.
//  Bubbles: in_valid=0 with en=1 injects a bubble (valid=0); data regs of a bubble are don't-care, but result
//    shall be held at its last valid value when out_valid=0 (no X/garbage on result).
//  Stages (registered at end of each):
//    S1 capture dataa, valid.
//    S2 sign = SIGNED & dataa[31]; mag = sign ? -dataa : dataa as 32-bit unsigned (-2^31 -> 32'h8000_0000).
//    S3 lz = count of leading zeros of mag (0..32); zero flag = (mag==0).
//    S4 norm = mag << lz (bit31 = hidden 1); exp = 158 - lz (= 127 + 31 - lz).
//    S5 round to nearest, ties to even: mant = norm[30:8]; G = norm[7]; S = |norm[6:0];
//       round_up = G & (S | mant[0]); {carry,mant} = mant + round_up; carry -> mant=0, exp=exp+1.
//    S6 pack: zero flag -> 32'h0 (+0.0, never -0.0); else {sign, exp[7:0], mant[22:0]}.
//  Range: |int32| < 2^32 so exp <= 158+1 = 159; no overflow, inf or NaN can be produced; no denormals.
//  Exact for |x| <= 2^24; above that, inexact results rounded as above (no inexact flag output).
//  Reset asserted mid-stream: all in-flight operands are discarded; first edge with reset=1 clears valid bits
//    regardless of en; no stale result emerges after reset deasserts.
//  Simultaneous reset and en=0: reset wins.
// TESTING
//  T1 SIGNED=1: dataa=1, then 0, then -1 (32'hFFFF_FFFF), back-to-back -> result 3F80_0000, 0000_0000, BF80_0000
//     on consecutive cycles, first one 6 edges after issue; out_valid high exactly those 3 cycles.
//  T2 SIGNED=1 extremes: 32'h8000_0000 -> CF00_0000; 32'h7FFF_FFFF -> 4F00_0000 (rounds up, exp carry).
//  T3 rounding: 16777217 (2^24+1) -> 4B80_0000 (tie, even); 16777219 -> 4B80_0002 (tie, up);
//     16777221 -> 4B80_0002 (tie, even); 33554435 -> 4C00_0001 (above half, up).
//  T4 SIGNED=0: 32'hFFFF_FFFF -> 4F80_0000; 32'h8000_0000 -> 4F00_0000; 123 -> 42F6_0000.
//  T5 stall: issue 5 operands, drop en for 3 cycles mid-flight -> same 5 results in order, each delayed by 3
//     cycles, outputs frozen during stall, no duplicate or lost out_valid pulse.
//  T6 reset mid-op: issue 4 operands, assert reset for 1 cycle at cycle 3 -> out_valid stays 0 for 6 cycles
//     afterwards, result=0; subsequent operand 2 -> 4000_0000 with normal latency.
//  Also: random int32 sweep (>=1e6 values, both SIGNED) vs C (float)x conversion model in RNE mode.

Source files
------------

// File: rtl/int2fp_convert.sv
// int2fp_convert: six-stage pipelined 32-bit integer to IEEE-754 single-precision converter.
// Results are rounded to nearest, ties to even. A global enable freezes every stage.
// A zero operand always packs to +0.0.
module int2fp_convert #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] dataa,
    output logic        out_valid,
    output logic [31:0] result
);

    // Leading-zero count of a 32-bit value. A zero input returns 32.
    // The ascending scan lets the highest set bit win.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                n = 6'(31 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even on a normalised value whose hidden bit is already stripped.
    // The return value is {carry, mant[22:0]}. A carry leaves mant at zero.
    function automatic logic [23:0] round_rne(input logic [30:0] norm);
        logic guard_bit;
        logic sticky_bit;
        logic round_up;
        guard_bit  = norm[7];
        sticky_bit = |norm[6:0];
        round_up   = guard_bit & (sticky_bit | norm[8]);
        return {1'b0, norm[30:8]} + {23'd0, round_up};
    endfunction

    // Stage 1 registers.
    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    // Stage 2 registers.
    logic        r_s2_valid;
    logic        r_s2_sign;
    logic [31:0] r_s2_mag;
    // Stage 3 registers.
    logic        r_s3_valid;
    logic        r_s3_sign;
    logic [31:0] r_s3_mag;
    logic [5:0]  r_s3_lz;
    logic        r_s3_zero;
    // Stage 4 registers.
    logic        r_s4_valid;
    logic        r_s4_sign;
    logic [30:0] r_s4_norm;
    logic [7:0]  r_s4_exp;
    logic        r_s4_zero;
    // Stage 5 registers.
    logic        r_s5_valid;
    logic        r_s5_sign;
    logic [7:0]  r_s5_exp;
    logic [22:0] r_s5_mant;
    logic        r_s5_zero;
    // Stage 6 registers, which drive the outputs.
    logic        r_s6_valid;
    logic [31:0] r_s6_result;

    // Combinational results feeding each register stage.
    logic        w_s2_sign;
    logic [31:0] w_s2_mag;
    logic [5:0]  w_s3_lz;
    logic        w_s3_zero;
    logic [30:0] w_s4_norm;
    logic [7:0]  w_s4_exp;
    logic [23:0] w_s5_rnd;
    logic [7:0]  w_s5_exp;
    logic [31:0] w_s6_result;

    // Per-stage datapath: sign/magnitude, leading-zero count, normalise, round, and pack.
    always_comb begin
        w_s2_sign = SIGNED & r_s1_data[31];
        if (w_s2_sign) begin
            w_s2_mag = 32'd0 - r_s1_data;
        end else begin
            w_s2_mag = r_s1_data;
        end

        w_s3_lz   = clz32(r_s2_mag);
        w_s3_zero = (r_s2_mag == 32'd0);

        w_s4_norm = 31'(r_s3_mag << r_s3_lz);
        w_s4_exp  = 8'd158 - {2'b00, r_s3_lz};

        w_s5_rnd  = round_rne(r_s4_norm);
        if (w_s5_rnd[23]) begin
            w_s5_exp = r_s4_exp + 8'd1;
        end else begin
            w_s5_exp = r_s4_exp;
        end

        if (r_s5_zero) begin
            w_s6_result = 32'h0000_0000;
        end else begin
            w_s6_result = {r_s5_sign, r_s5_exp, r_s5_mant};
        end
    end

    // Pipeline registers. Reset clears everything, en=0 holds every stage,
    // and the output result only updates on a valid conversion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= 32'd0;
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_mag    <= 32'd0;
            r_s3_valid  <= 1'b0;
            r_s3_sign   <= 1'b0;
            r_s3_mag    <= 32'd0;
            r_s3_lz     <= 6'd0;
            r_s3_zero   <= 1'b0;
            r_s4_valid  <= 1'b0;
            r_s4_sign   <= 1'b0;
            r_s4_norm   <= 31'd0;
            r_s4_exp    <= 8'd0;
            r_s4_zero   <= 1'b0;
            r_s5_valid  <= 1'b0;
            r_s5_sign   <= 1'b0;
            r_s5_exp    <= 8'd0;
            r_s5_mant   <= 23'd0;
            r_s5_zero   <= 1'b0;
            r_s6_valid  <= 1'b0;
            r_s6_result <= 32'd0;
        end else if (en) begin
            r_s1_valid  <= in_valid;
            r_s1_data   <= dataa;
            r_s2_valid  <= r_s1_valid;
            r_s2_sign   <= w_s2_sign;
            r_s2_mag    <= w_s2_mag;
            r_s3_valid  <= r_s2_valid;
            r_s3_sign   <= r_s2_sign;
            r_s3_mag    <= r_s2_mag;
            r_s3_lz     <= w_s3_lz;
            r_s3_zero   <= w_s3_zero;
            r_s4_valid  <= r_s3_valid;
            r_s4_sign   <= r_s3_sign;
            r_s4_norm   <= w_s4_norm;
            r_s4_exp    <= w_s4_exp;
            r_s4_zero   <= r_s3_zero;
            r_s5_valid  <= r_s4_valid;
            r_s5_sign   <= r_s4_sign;
            r_s5_exp    <= w_s5_exp;
            r_s5_mant   <= w_s5_rnd[22:0];
            r_s5_zero   <= r_s4_zero;
            r_s6_valid  <= r_s5_valid;
            if (r_s5_valid) begin
                r_s6_result <= w_s6_result;
            end else begin
                r_s6_result <= r_s6_result;
            end
        end else begin
            r_s6_valid  <= r_s6_valid;
            r_s6_result <= r_s6_result;
        end
    end

    assign out_valid = r_s6_valid;
    assign result    = r_s6_result;

endmodule

// File: tb/tb_int2fp_convert.sv
// Directed testbench for int2fp_convert. It drives a signed and an unsigned instance
// from the same stimulus and checks both against hand-computed fp32 patterns.
module tb_int2fp_convert;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        in_valid;
    logic [31:0] dataa;
    logic        out_valid_s;
    logic [31:0] result_s;
    logic        out_valid_u;
    logic [31:0] result_u;

    int n_assert = 0;
    int n_fail   = 0;

    int2fp_convert #(.SIGNED(1'b1)) u_s (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .in_valid (in_valid),
        .dataa    (dataa),
        .out_valid(out_valid_s),
        .result   (result_s)
    );

    int2fp_convert #(.SIGNED(1'b0)) u_u (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .in_valid (in_valid),
        .dataa    (dataa),
        .out_valid(out_valid_u),
        .result   (result_u)
    );

    always #5 clock = ~clock;

    // Apply one cycle of inputs, then return at the following falling edge.
    task automatic tick(input logic e, input logic v, input logic [31:0] d);
        en       = e;
        in_valid = v;
        dataa    = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Run n enabled cycles with no operand.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b1, 1'b0, 32'd0);
        end
    endtask

    // Compare one instance's outputs against the expected values.
    task automatic chk(input string tag, input logic ov, input logic [31:0] orr,
                       input logic ev, input logic [31:0] er);
        n_assert++;
        assert (ov === ev && orr === er) else begin
            n_fail++;
            $error("FAIL %s: observed valid=%0b result=%h, expected valid=%0b result=%h",
                   tag, ov, orr, ev, er);
        end
    endtask

    // Check both instances in one step.
    task automatic chk2(input string tag, input logic evs, input logic [31:0] ers,
                        input logic evu, input logic [31:0] eru);
        chk({tag, "_s"}, out_valid_s, result_s, evs, ers);
        chk({tag, "_u"}, out_valid_u, result_u, evu, eru);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        dataa    = 32'd0;
        @(negedge clock);
        // Reset with en low: reset still clears the pipe.
        tick(1'b0, 1'b1, 32'h1234_5678);
        tick(1'b0, 1'b0, 32'd0);
        reset = 1'b0;
        chk2("reset", 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);

        // T1: 1, 0, -1 issued back to back.
        tick(1'b1, 1'b1, 32'd1);
        tick(1'b1, 1'b1, 32'd0);
        tick(1'b1, 1'b1, 32'hFFFF_FFFF);
        idle(2);
        chk2("t1_not_early", 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        idle(1);
        chk2("t1_one",  1'b1, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
        idle(1);
        chk2("t1_zero", 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000);
        idle(1);
        chk2("t1_m1",   1'b1, 32'hBF80_0000, 1'b1, 32'h4F80_0000);
        idle(1);
        chk2("t1_held", 1'b0, 32'hBF80_0000, 1'b0, 32'h4F80_0000);

        // T2: extremes.
        tick(1'b1, 1'b1, 32'h8000_0000);
        tick(1'b1, 1'b1, 32'h7FFF_FFFF);
        idle(4);
        chk2("t2_min",  1'b1, 32'hCF00_0000, 1'b1, 32'h4F00_0000);
        idle(1);
        chk2("t2_max",  1'b1, 32'h4F00_0000, 1'b1, 32'h4F00_0000);
        idle(1);
        chk2("t2_held", 1'b0, 32'h4F00_0000, 1'b0, 32'h4F00_0000);

        // T3: rounding cases.
        tick(1'b1, 1'b1, 32'd16777217);
        tick(1'b1, 1'b1, 32'd16777219);
        tick(1'b1, 1'b1, 32'd16777221);
        tick(1'b1, 1'b1, 32'd33554435);
        idle(2);
        chk2("t3_tie_even_lo", 1'b1, 32'h4B80_0000, 1'b1, 32'h4B80_0000);
        idle(1);
        chk2("t3_tie_up",      1'b1, 32'h4B80_0002, 1'b1, 32'h4B80_0002);
        idle(1);
        chk2("t3_tie_even_hi", 1'b1, 32'h4B80_0002, 1'b1, 32'h4B80_0002);
        idle(1);
        chk2("t3_above_half",  1'b1, 32'h4C00_0001, 1'b1, 32'h4C00_0001);
        idle(1);
        chk2("t3_held",        1'b0, 32'h4C00_0001, 1'b0, 32'h4C00_0001);

        // T4: unsigned interpretation, compared with the signed instance.
        tick(1'b1, 1'b1, 32'hFFFF_FFFF);
        tick(1'b1, 1'b1, 32'h8000_0000);
        tick(1'b1, 1'b1, 32'd123);
        idle(3);
        chk2("t4_allones", 1'b1, 32'hBF80_0000, 1'b1, 32'h4F80_0000);
        idle(1);
        chk2("t4_msb",     1'b1, 32'hCF00_0000, 1'b1, 32'h4F00_0000);
        idle(1);
        chk2("t4_123",     1'b1, 32'h42F6_0000, 1'b1, 32'h42F6_0000);
        idle(1);
        chk2("t4_held",    1'b0, 32'h42F6_0000, 1'b0, 32'h42F6_0000);

        // T5: five operands, then a 3-cycle stall while results are draining.
        tick(1'b1, 1'b1, 32'd1);
        tick(1'b1, 1'b1, 32'd2);
        tick(1'b1, 1'b1, 32'd3);
        tick(1'b1, 1'b1, 32'd4);
        tick(1'b1, 1'b1, 32'd5);
        idle(1);
        chk2("t5_r1", 1'b1, 32'h3F80_0000, 1'b1, 32'h3F80_0000);
        idle(1);
        chk2("t5_r2", 1'b1, 32'h4000_0000, 1'b1, 32'h4000_0000);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 32'd99);
            chk2("t5_stall", 1'b1, 32'h4000_0000, 1'b1, 32'h4000_0000);
        end
        idle(1);
        chk2("t5_r3", 1'b1, 32'h4040_0000, 1'b1, 32'h4040_0000);
        idle(1);
        chk2("t5_r4", 1'b1, 32'h4080_0000, 1'b1, 32'h4080_0000);
        idle(1);
        chk2("t5_r5", 1'b1, 32'h40A0_0000, 1'b1, 32'h40A0_0000);
        idle(1);
        chk2("t5_end", 1'b0, 32'h40A0_0000, 1'b0, 32'h40A0_0000);

        // T6: reset in the middle of a stream, asserted together with en=0.
        tick(1'b1, 1'b1, 32'd7);
        tick(1'b1, 1'b1, 32'd8);
        tick(1'b1, 1'b1, 32'd9);
        reset = 1'b1;
        tick(1'b0, 1'b1, 32'd10);
        reset = 1'b0;
        chk2("t6_rst", 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            chk2("t6_flushed", 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        end
        tick(1'b1, 1'b1, 32'd2);
        idle(4);
        chk2("t6_not_early", 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000);
        idle(1);
        chk2("t6_two", 1'b1, 32'h4000_0000, 1'b1, 32'h4000_0000);
        idle(1);
        chk2("t6_held", 1'b0, 32'h4000_0000, 1'b0, 32'h4000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
